// File: rtl/wt_cache_controller.sv
// Direct-mapped write-through, no-write-allocate data cache with a posted write buffer.
// Latency: read hit 0 cycles (combinational); read miss >= 2 cycles; writes retire in 0 cycles.
// Backpressure: stall holds the CPU during refill/drain-before-refill or when the write buffer is full.

// Generic synchronous FIFO used for the posted write buffer.
// Latency: a pushed entry is visible at the head on the next cycle.
// Backpressure: push_rdy drops when full; a pop in the same cycle does not free a slot early.
module wt_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic          core_clk,
    input  logic          arst_n,
    input  logic          push_vld,
    output logic          push_rdy,
    input  logic [DW-1:0] push_dat,
    output logic          pop_vld,
    input  logic          pop_rdy,
    output logic [DW-1:0] pop_dat
);
    localparam int PW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [PW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign push_rdy = (count_q != (PW+1)'(DEPTH));
    assign pop_vld  = (count_q != '0);
    assign pop_dat  = mem_q[rd_ptr_q];
    assign do_push  = push_vld & push_rdy;
    assign do_pop   = pop_vld & pop_rdy;

    // Pointer and occupancy bookkeeping; pointers wrap naturally at the power-of-2 depth.
    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (PW+1)'(1);
                2'b01:   count_q <= count_q - (PW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge core_clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_dat;
    end
endmodule

module wt_cache_controller #(
    parameter int ADDR_WIDTH      = 10,
    parameter int WIDTH           = 32,
    parameter int WORDS_PER_BLOCK = 4,
    parameter int LINES           = 32,
    parameter int WB_DEPTH        = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [ADDR_WIDTH-1:0]            WordAddress,
    input  logic [WIDTH-1:0]                 DataIn,
    input  logic                             mem_read,
    input  logic                             mem_write,
    output logic                             stall,
    output logic [WIDTH-1:0]                 DataOut,
    output logic                             main_read,
    output logic                             main_write,
    output logic [ADDR_WIDTH-1:0]            main_addr,
    output logic [WIDTH-1:0]                 main_wdata,
    input  logic                             ready,
    input  logic [WIDTH*WORDS_PER_BLOCK-1:0] main_rblock
);
    localparam int OFF_BITS  = $clog2(WORDS_PER_BLOCK);
    localparam int IDX_BITS  = $clog2(LINES);
    localparam int TAG_BITS  = ADDR_WIDTH - IDX_BITS - OFF_BITS;
    localparam int LINE_BITS = ADDR_WIDTH - OFF_BITS;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_WB = 2'd1,
        REFILL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [WIDTH-1:0]      dat;
    } wb_entry_t;

    // Cache storage: only the valid bits are reset, data and tags keep stale contents.
    logic [WIDTH-1:0]    data_q [LINES][WORDS_PER_BLOCK];
    logic [TAG_BITS-1:0] tag_q  [LINES];
    logic [LINES-1:0]    valid_q;

    state_t               state_q;
    logic [LINE_BITS-1:0] miss_line_q;

    logic [TAG_BITS-1:0]  cpu_tag;
    logic [IDX_BITS-1:0]  cpu_idx;
    logic [OFF_BITS-1:0]  cpu_off;
    logic [IDX_BITS-1:0]  miss_idx;
    logic [TAG_BITS-1:0]  miss_tag;
    logic                 hit;
    logic                 rd_req;
    logic                 rd_miss;
    logic                 cpu_wr_acc;
    logic                 refill_done;
    logic                 drain;

    wb_entry_t            wb_push_dat;
    wb_entry_t            wb_head;
    logic                 wb_push_rdy;
    logic                 wb_pop_vld;
    logic                 wb_pop;
    logic                 wb_full;
    logic                 wb_empty;

    // Address split: tag in the MSBs, then index, then word offset.
    assign cpu_tag  = WordAddress[ADDR_WIDTH-1 -: TAG_BITS];
    assign cpu_idx  = WordAddress[OFF_BITS +: IDX_BITS];
    assign cpu_off  = WordAddress[OFF_BITS-1:0];
    assign miss_idx = miss_line_q[IDX_BITS-1:0];
    assign miss_tag = miss_line_q[LINE_BITS-1 -: TAG_BITS];

    assign hit     = valid_q[cpu_idx] & (tag_q[cpu_idx] == cpu_tag);
    assign DataOut = data_q[cpu_idx][cpu_off];

    // A simultaneous read and write is handled purely as a write.
    assign rd_req      = mem_read & ~mem_write;
    assign rd_miss     = (state_q == IDLE) & rd_req & ~hit;
    assign cpu_wr_acc  = (state_q == IDLE) & mem_write & ~wb_full;
    assign refill_done = (state_q == REFILL) & ready;

    assign stall = (state_q != IDLE) | (rd_req & ~hit) | (mem_write & wb_full);

    // Drain the buffer head whenever the memory port is not busy with a refill.
    assign wb_full  = ~wb_push_rdy;
    assign wb_empty = ~wb_pop_vld;
    assign drain    = wb_pop_vld & (state_q != REFILL);
    assign wb_pop   = drain & ready;

    assign wb_push_dat.addr = WordAddress;
    assign wb_push_dat.dat  = DataIn;

    wt_fifo #(
        .DW    ($bits(wb_entry_t)),
        .DEPTH (WB_DEPTH)
    ) u_wb (
        .core_clk (clk),
        .arst_n   (reset),
        .push_vld (cpu_wr_acc),
        .push_rdy (wb_push_rdy),
        .push_dat (wb_push_dat),
        .pop_vld  (wb_pop_vld),
        .pop_rdy  (wb_pop),
        .pop_dat  (wb_head)
    );

    // Memory port: both requests decode from registered state, so they can never overlap.
    assign main_read  = (state_q == REFILL);
    assign main_write = drain;

    // Address mux: latched refill line while refilling, buffer head while draining, else zero.
    always_comb begin
        main_addr  = '0;
        main_wdata = '0;
        if (state_q == REFILL) begin
            main_addr = {miss_line_q, {OFF_BITS{1'b0}}};
        end else if (drain) begin
            main_addr  = wb_head.addr;
            main_wdata = wb_head.dat;
        end
    end

    // Miss FSM: wait for the buffer to drain so the refill sees all posted writes, then refill.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            miss_line_q <= '0;
            valid_q     <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (rd_miss) begin
                        miss_line_q <= WordAddress[ADDR_WIDTH-1:OFF_BITS];
                        state_q     <= wb_empty ? REFILL : WAIT_WB;
                    end
                end
                WAIT_WB: begin
                    if (wb_empty) state_q <= REFILL;
                end
                REFILL: begin
                    if (ready) begin
                        valid_q[miss_idx] <= 1'b1;
                        state_q           <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Line fill on refill completion; write hits update the cached word in place.
    always_ff @(posedge clk) begin
        if (refill_done) begin
            tag_q[miss_idx] <= miss_tag;
            for (int w = 0; w < WORDS_PER_BLOCK; w++) begin
                data_q[miss_idx][w] <= main_rblock[w*WIDTH +: WIDTH];
            end
        end else if (cpu_wr_acc && hit) begin
            data_q[cpu_idx][cpu_off] <= DataIn;
        end
    end
endmodule

// File: tb/tb_wt_cache_controller.sv
// Scoreboard bench for wt_cache_controller with a behavioural main-memory model.
// Latency: memory answers after a programmable number of wait cycles, or under manual ready control.
// Backpressure: CPU driver holds each request until stall is sampled low.
module tb_wt_cache_controller;
    logic         clk;
    logic         reset;
    logic [9:0]   WordAddress;
    logic [31:0]  DataIn;
    logic         mem_read;
    logic         mem_write;
    logic         stall;
    logic [31:0]  DataOut;
    logic         main_read;
    logic         main_write;
    logic [9:0]   main_addr;
    logic [31:0]  main_wdata;
    logic         ready;
    logic [127:0] main_rblock;

    int checks = 0;
    int failures = 0;

    logic [41:0] wr_q [$];
    logic [9:0]  rf_q [$];
    logic [31:0] do_q [$];

    logic [31:0] mem [1024];
    int          mem_lat;
    logic        manual;
    logic        manual_ready;
    logic        model_ready;

    assign ready = manual ? manual_ready : model_ready;

    wt_cache_controller dut (
        .clk         (clk),
        .reset       (reset),
        .WordAddress (WordAddress),
        .DataIn      (DataIn),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .stall       (stall),
        .DataOut     (DataOut),
        .main_read   (main_read),
        .main_write  (main_write),
        .main_addr   (main_addr),
        .main_wdata  (main_wdata),
        .ready       (ready),
        .main_rblock (main_rblock)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        failures++;
        $display("FAIL %s", nm);
    endtask

    // Main-memory model: ready after mem_lat wait cycles, one cycle wide.
    initial begin
        model_ready = 1'b0;
        main_rblock = '0;
        for (int a = 0; a < 1024; a++) mem[a] = 32'hA000_0000 | a;
        mem[4] = 32'h00; mem[5] = 32'h11; mem[6] = 32'h22; mem[7] = 32'h33;
        begin
            int wcnt;
            wcnt = 0;
            forever begin
                @(posedge clk);
                #1;
                if (!reset || manual || model_ready) begin
                    model_ready = 1'b0;
                    wcnt = 0;
                end else if (main_read || main_write) begin
                    if (wcnt >= mem_lat) begin
                        model_ready = 1'b1;
                        if (main_write) mem[main_addr] = main_wdata;
                        else for (int i = 0; i < 4; i++) main_rblock[i*32 +: 32] = mem[10'(main_addr + i)];
                    end else begin
                        wcnt++;
                    end
                end
            end
        end
    end

    // Monitor: pop the matching expectation whenever the DUT completes a transfer.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                if (main_write && ready) begin
                    if (wr_q.size() == 0) fail_now("unexpected_main_write");
                    else begin
                        logic [41:0] e;
                        e = wr_q.pop_front();
                        check("drain_addr", {22'd0, main_addr}, {22'd0, e[41:32]});
                        check("drain_data", main_wdata, e[31:0]);
                    end
                end
                if (main_read && ready) begin
                    if (rf_q.size() == 0) fail_now("unexpected_main_read");
                    else begin
                        logic [9:0] ra;
                        ra = rf_q.pop_front();
                        check("refill_addr", {22'd0, main_addr}, {22'd0, ra});
                    end
                end
                if (mem_read && !mem_write && !stall) begin
                    if (do_q.size() == 0) fail_now("unexpected_read_data");
                    else begin
                        logic [31:0] d;
                        d = do_q.pop_front();
                        check("read_data", DataOut, d);
                    end
                end
            end
        end
    end

    task automatic cpu_read(input logic [9:0] a, output int ncyc, output int rd_first, output int wr_before);
        @(posedge clk);
        #1;
        WordAddress = a;
        mem_read = 1'b1;
        ncyc = 0;
        rd_first = -1;
        wr_before = 0;
        forever begin
            @(negedge clk);
            if (rd_first < 0 && main_write && ready) wr_before++;
            if (main_read && rd_first < 0) rd_first = ncyc;
            if (!stall) break;
            ncyc++;
            if (ncyc > 300) begin
                fail_now("read_timeout");
                break;
            end
        end
        @(posedge clk);
        #1;
        mem_read = 1'b0;
    endtask

    task automatic cpu_write(input logic [9:0] a, input logic [31:0] d, output int ncyc);
        wr_q.push_back({a, d});
        @(posedge clk);
        #1;
        WordAddress = a;
        DataIn = d;
        mem_write = 1'b1;
        ncyc = 0;
        forever begin
            @(negedge clk);
            if (!stall) break;
            ncyc++;
            if (ncyc > 300) begin
                fail_now("write_timeout");
                break;
            end
        end
        @(posedge clk);
        #1;
        mem_write = 1'b0;
    endtask

    task automatic wait_drain;
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (!main_write && !main_read) break;
            n++;
            if (n > 300) begin
                fail_now("drain_timeout");
                break;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog_expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int nc, rf, wb;
        reset = 1'b0;
        WordAddress = '0;
        DataIn = '0;
        mem_read = 1'b0;
        mem_write = 1'b0;
        manual = 1'b0;
        manual_ready = 1'b0;
        mem_lat = 3;

        // Reset state
        #12;
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_main_read", {31'd0, main_read}, 32'd0);
        check("rst_main_write", {31'd0, main_write}, 32'd0);
        check("rst_main_addr", {22'd0, main_addr}, 32'd0);
        check("rst_main_wdata", main_wdata, 32'd0);
        #10;
        reset = 1'b1;

        // Read miss with 3 wait cycles, then a hit in the same line
        rf_q.push_back(10'h004);
        do_q.push_back(32'h11);
        cpu_read(10'h005, nc, rf, wb);
        check("miss_stall_cycles", nc, 5);
        check("miss_main_read_cycle", rf, 1);
        do_q.push_back(32'h22);
        cpu_read(10'h006, nc, rf, wb);
        check("hit_stall_cycles", nc, 0);
        check("hit_no_refill", rf, 32'hFFFF_FFFF);

        // Write hit: no stall, posted to memory, cache updated
        mem_lat = 1;
        cpu_write(10'h005, 32'hDEADBEEF, nc);
        check("whit_stall_cycles", nc, 0);
        @(negedge clk);
        check("whit_main_write", {31'd0, main_write}, 32'd1);
        check("whit_main_addr", {22'd0, main_addr}, 32'h005);
        check("whit_main_wdata", main_wdata, 32'hDEADBEEF);
        do_q.push_back(32'hDEADBEEF);
        cpu_read(10'h005, nc, rf, wb);
        check("whit_read_no_refill", rf, 32'hFFFF_FFFF);
        wait_drain();

        // Write miss: no allocate, so the following read misses
        cpu_write(10'h3F0, 32'h12345678, nc);
        check("wmiss_stall_cycles", nc, 0);
        wait_drain();
        rf_q.push_back(10'h3F0);
        do_q.push_back(32'h12345678);
        cpu_read(10'h3F0, nc, rf, wb);
        check("wmiss_read_misses", {31'd0, rf >= 0}, 32'd1);

        // Buffer full: four writes retire, the fifth stalls until a pop has happened
        manual = 1'b1;
        manual_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cpu_write(10'h100 + 10'(i), 32'hB000_0000 + i, nc);
            check("fill_stall_cycles", nc, 0);
        end
        wr_q.push_back({10'h104, 32'hB000_0004});
        @(posedge clk);
        #1;
        WordAddress = 10'h104;
        DataIn = 32'hB000_0004;
        mem_write = 1'b1;
        @(negedge clk);
        check("full_stall", {31'd0, stall}, 32'd1);
        @(posedge clk);
        #1;
        manual_ready = 1'b1;
        @(negedge clk);
        check("full_pop_cycle_stall", {31'd0, stall}, 32'd1);
        @(posedge clk);
        #1;
        manual_ready = 1'b0;
        @(negedge clk);
        check("full_after_pop_stall", {31'd0, stall}, 32'd0);
        @(posedge clk);
        #1;
        mem_write = 1'b0;
        manual = 1'b0;
        wait_drain();

        // Read miss behind two pending writes: both drain before the refill starts
        manual = 1'b1;
        manual_ready = 1'b0;
        cpu_write(10'h200, 32'hCAFE0001, nc);
        check("pend_w0_stall", nc, 0);
        cpu_write(10'h201, 32'hCAFE0002, nc);
        check("pend_w1_stall", nc, 0);
        rf_q.push_back(10'h084);
        do_q.push_back(32'hA000_0085);
        fork
            cpu_read(10'h085, nc, rf, wb);
            begin
                repeat (4) @(posedge clk);
                #2;
                manual = 1'b0;
            end
        join
        check("pend_writes_before_read", wb, 2);
        check("pend_read_missed", {31'd0, rf >= 0}, 32'd1);

        // Conflict misses on index 1, then reset during a refill
        rf_q.push_back(10'h004);
        do_q.push_back(32'hDEADBEEF);
        cpu_read(10'h005, nc, rf, wb);
        check("evict_a_miss", {31'd0, rf >= 0}, 32'd1);
        rf_q.push_back(10'h084);
        do_q.push_back(32'hA000_0085);
        cpu_read(10'h085, nc, rf, wb);
        check("evict_b_miss", {31'd0, rf >= 0}, 32'd1);
        mem_lat = 6;
        @(posedge clk);
        #1;
        WordAddress = 10'h005;
        mem_read = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst_main_read_before", {31'd0, main_read}, 32'd1);
        #2;
        reset = 1'b0;
        mem_read = 1'b0;
        #1;
        check("midrst_main_read", {31'd0, main_read}, 32'd0);
        check("midrst_stall", {31'd0, stall}, 32'd0);
        check("midrst_main_write", {31'd0, main_write}, 32'd0);
        check("midrst_main_addr", {22'd0, main_addr}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        mem_lat = 1;
        rf_q.push_back(10'h084);
        do_q.push_back(32'hA000_0085);
        cpu_read(10'h085, nc, rf, wb);
        check("postrst_miss_cycle", rf, 1);
        check("postrst_stall_cycles", nc, 3);

        repeat (5) @(negedge clk);
        check("scoreboard_empty", wr_q.size() + rf_q.size() + do_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
